// File: rtl/svreal_capture_fifo_pkg.sv
// Shared alignment helpers and counter types for the fixed-point capture FIFO.
package svreal_capture_pkg;

    localparam int DROP_W = 8;
    typedef logic [DROP_W-1:0] drop_cnt_t;

    // Positive result means the input LSB is coarser than the output LSB.
    function automatic int align_shift(input int in_exp, input int out_exp);
        return in_exp - out_exp;
    endfunction

    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/svreal_capture_fifo_if.sv
// Sample-in / realigned-sample-out handshake bundle of the capture FIFO.
interface svreal_capture_fifo_if #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 18
);
    logic [IN_WIDTH-1:0]  in_value;
    logic                 in_valid;
    logic [OUT_WIDTH-1:0] out_value;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_value, in_valid, out_ready,
        input  out_value, out_valid
    );

    modport slave (
        input  in_value, in_valid, out_ready,
        output out_value, out_valid
    );
endinterface

// File: rtl/svreal_capture_fifo_align.sv
// Combinational re-alignment of a signed fixed-point word to a new exponent/width,
// flooring on right shifts and clamping to the output range.
module svreal_align
    import svreal_capture_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int IN_EXP    = -8,
    parameter int OUT_WIDTH = 18,
    parameter int OUT_EXP   = -10
) (
    input  logic [IN_WIDTH-1:0]  in_value_i,
    output logic [OUT_WIDTH-1:0] out_value_o,
    output logic                 sat_o
);
    localparam int SHIFT = align_shift(IN_EXP, OUT_EXP);
    localparam int LSH   = (SHIFT > 0) ? SHIFT : 0;
    localparam int RSH   = (SHIFT < 0) ? -SHIFT : 0;
    localparam int EXT_W = IN_WIDTH + LSH;
    // One guard bit above both ranges keeps the signed compares exact.
    localparam int CMP_W = imax(EXT_W, OUT_WIDTH) + 1;

    localparam logic signed [CMP_W-1:0] MAX_V = CMP_W'(sat_max(OUT_WIDTH));
    localparam logic signed [CMP_W-1:0] MIN_V = CMP_W'(sat_min(OUT_WIDTH));

    logic signed [CMP_W-1:0] ext;
    logic signed [CMP_W-1:0] shifted;

    assign ext     = {{(CMP_W-IN_WIDTH){in_value_i[IN_WIDTH-1]}}, in_value_i};
    assign shifted = (ext <<< LSH) >>> RSH;

    always_comb begin
        out_value_o = shifted[OUT_WIDTH-1:0];
        sat_o       = 1'b0;
        if (shifted > MAX_V) begin
            out_value_o = MAX_V[OUT_WIDTH-1:0];
            sat_o       = 1'b1;
        end else if (shifted < MIN_V) begin
            out_value_o = MIN_V[OUT_WIDTH-1:0];
            sat_o       = 1'b1;
        end
    end
endmodule

// File: rtl/svreal_capture_fifo.sv
// Captures strobed fixed-point samples, realigns them and buffers them in a
// first-word-fall-through FIFO; samples arriving at a full FIFO are counted and dropped.
module svreal_capture_fifo
    import svreal_capture_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int IN_EXP    = -8,
    parameter int OUT_WIDTH = 18,
    parameter int OUT_EXP   = -10,
    parameter int DEPTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    svreal_capture_fifo_if.slave     bus,
    output logic                     sat_flag,
    output drop_cnt_t                drop_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [OUT_WIDTH-1:0] aligned;
    logic                 aligned_sat;

    svreal_align #(
        .IN_WIDTH  (IN_WIDTH),
        .IN_EXP    (IN_EXP),
        .OUT_WIDTH (OUT_WIDTH),
        .OUT_EXP   (OUT_EXP)
    ) u_align (
        .in_value_i  (bus.in_value),
        .out_value_o (aligned),
        .sat_o       (aligned_sat)
    );

    logic                 s1_valid_q;
    logic [OUT_WIDTH-1:0] s1_value_q;
    logic                 s1_sat_q;

    logic [OUT_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [OUT_WIDTH-1:0] last_q, last_d;
    logic                 sat_q, sat_d;
    drop_cnt_t            drop_q, drop_d;

    logic empty, full, pop, push, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && bus.out_ready;
    // A full FIFO still accepts when its head leaves on the same edge.
    assign push  = s1_valid_q && (!full || pop);
    assign drop  = s1_valid_q && !push;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (pop  ? 1'b1 : 1'b0);
        last_d   = pop ? mem_q[rd_ptr_q[AW-1:0]] : last_q;
        sat_d    = sat_q | (push & s1_sat_q);
        drop_d   = (drop && (drop_q != '1)) ? drop_q + 1'b1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_value_q <= '0;
            s1_sat_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            last_q     <= '0;
            sat_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            s1_valid_q <= bus.in_valid;
            s1_value_q <= aligned;
            s1_sat_q   <= aligned_sat;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            last_q     <= last_d;
            sat_q      <= sat_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s1_value_q;
        end
    end

    // When empty the last popped word stays visible (zero straight after reset).
    assign bus.out_value = empty ? last_q : mem_q[rd_ptr_q[AW-1:0]];
    assign bus.out_valid = !empty;
    assign sat_flag      = sat_q;
    assign drop_count    = drop_q;
    assign level         = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_svreal_capture_fifo.sv
// Drives three capture FIFOs (default, OUT_WIDTH=12, OUT_EXP=-6) in lockstep against a queue model.
module tb_svreal_capture_fifo;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    svreal_capture_fifo_if #(.IN_WIDTH(16), .OUT_WIDTH(18)) if_a ();
    svreal_capture_fifo_if #(.IN_WIDTH(16), .OUT_WIDTH(12)) if_b ();
    svreal_capture_fifo_if #(.IN_WIDTH(16), .OUT_WIDTH(18)) if_c ();

    logic       sat_a, sat_b, sat_c;
    logic [7:0] dc_a, dc_b, dc_c;
    logic [3:0] lvl_a, lvl_b, lvl_c;

    svreal_capture_fifo #(.IN_WIDTH(16), .IN_EXP(-8), .OUT_WIDTH(18), .OUT_EXP(-10), .DEPTH(DEPTH))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a), .sat_flag(sat_a), .drop_count(dc_a), .level(lvl_a));
    svreal_capture_fifo #(.IN_WIDTH(16), .IN_EXP(-8), .OUT_WIDTH(12), .OUT_EXP(-10), .DEPTH(DEPTH))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b), .sat_flag(sat_b), .drop_count(dc_b), .level(lvl_b));
    svreal_capture_fifo #(.IN_WIDTH(16), .IN_EXP(-8), .OUT_WIDTH(18), .OUT_EXP(-6), .DEPTH(DEPTH))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c), .sat_flag(sat_c), .drop_count(dc_c), .level(lvl_c));

    int checks   = 0;
    int failures = 0;

    int shift_k [3] = '{2, 2, -2};
    int ow_k    [3] = '{18, 12, 18};

    // Reference model: raw samples in the FIFO, one pending pipeline sample.
    int q [$];
    bit pend_v;
    int pend_raw;
    int drops;
    bit sat_m [3];
    bit last_v;
    int last_raw;

    function automatic real ref_real(int raw, int k);
        real r, hi, lo;
        r  = $floor(raw * (2.0 ** shift_k[k]));
        hi = (2.0 ** (ow_k[k] - 1)) - 1.0;
        lo = -(2.0 ** (ow_k[k] - 1));
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

    function automatic int ref_val(int raw, int k);
        return $rtoi(ref_real(raw, k));
    endfunction

    function automatic bit ref_sat(int raw, int k);
        return ($floor(raw * (2.0 ** shift_k[k])) != ref_real(raw, k));
    endfunction

    task automatic model_reset();
        q.delete();
        pend_v = 0; pend_raw = 0; drops = 0;
        last_v = 0; last_raw = 0;
        for (int k = 0; k < 3; k++) sat_m[k] = 0;
    endtask

    task automatic model_edge(bit v, int raw, bit r);
        if (q.size() > 0 && r) begin
            last_raw = q.pop_front();
            last_v   = 1;
        end
        if (pend_v) begin
            if (q.size() < DEPTH) begin
                q.push_back(pend_raw);
                for (int k = 0; k < 3; k++) sat_m[k] = sat_m[k] | ref_sat(pend_raw, k);
            end else if (drops < 255) begin
                drops++;
            end
        end
        pend_v   = v;
        pend_raw = raw;
    endtask

    task automatic chk(string tag, integer obs, integer exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(string tag, int k, integer ov, integer oval, integer lvl, integer dc, integer sf);
        integer exp_val;
        if (q.size() > 0)  exp_val = ref_val(q[0], k);
        else if (last_v)   exp_val = ref_val(last_raw, k);
        else               exp_val = 0;
        chk({tag, ".out_valid"},  ov,   (q.size() > 0) ? 1 : 0);
        chk({tag, ".out_value"},  oval, exp_val);
        chk({tag, ".level"},      lvl,  q.size());
        chk({tag, ".drop_count"}, dc,   drops);
        chk({tag, ".sat_flag"},   sf,   sat_m[k]);
    endtask

    task automatic check_all(string tag);
        chk_dut({tag, "/A"}, 0, if_a.out_valid, $signed(if_a.out_value), lvl_a, dc_a, sat_a);
        chk_dut({tag, "/B"}, 1, if_b.out_valid, $signed(if_b.out_value), lvl_b, dc_b, sat_b);
        chk_dut({tag, "/C"}, 2, if_c.out_valid, $signed(if_c.out_value), lvl_c, dc_c, sat_c);
    endtask

    task automatic drive(bit v, int raw, bit r);
        if_a.in_valid = v; if_a.in_value = raw[15:0]; if_a.out_ready = r;
        if_b.in_valid = v; if_b.in_value = raw[15:0]; if_b.out_ready = r;
        if_c.in_valid = v; if_c.in_value = raw[15:0]; if_c.out_ready = r;
    endtask

    task automatic step(string tag, bit v, int raw, bit r);
        drive(v, raw, r);
        @(posedge clk);
        model_edge(v, raw, r);
        #1;
        check_all(tag);
    endtask

    function automatic int rand_sample();
        shortint s;
        s = shortint'($urandom);
        return int'(s);
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0);
        model_reset();
        #12;
        check_all("reset");
        #2 rst_n = 1'b1;

        // Basic conversion and two-edge latency; B saturates on 1167.
        step("basic0", 1, 315, 1);
        step("basic1", 1, 1167, 1);
        for (int i = 0; i < 3; i++) step("basic_idle", 0, 0, 1);

        // Negative shift floors toward -infinity on C.
        step("floor0", 1, -315, 1);
        step("floor1", 1, 315, 1);
        for (int i = 0; i < 3; i++) step("floor_idle", 0, 0, 1);

        // Overfill: 11 samples with no reader.
        for (int i = 0; i < 11; i++) step("fill", 1, rand_sample(), 0);
        step("fill_settle", 0, 0, 0);
        // Full FIFO with concurrent push and pop across the pointer wrap.
        for (int i = 0; i < 4; i++) step("full_pp", 1, rand_sample(), 1);
        for (int i = 0; i < 12; i++) step("drain", 0, 0, 1);

        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), rand_sample(), ($urandom_range(0, 3) != 0));
        for (int i = 0; i < 12; i++) step("rand_drain", 0, 0, 1);

        // Drop counter saturates at 255.
        for (int i = 0; i < 275; i++) step("drop_sat", 1, rand_sample(), 0);
        for (int i = 0; i < 12; i++) step("drop_drain", 0, 0, 1);

        // Asynchronous reset with five words buffered.
        for (int i = 0; i < 5; i++) step("pre_rst", 1, rand_sample(), 0);
        step("pre_rst_settle", 0, 0, 0);
        chk("pre_rst.level5", lvl_a, 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #2 rst_n = 1'b1;
        step("post_rst0", 1, rand_sample(), 1);
        for (int i = 0; i < 3; i++) step("post_rst", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
